// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronise and debounce board switches for the picoMIPS cpu
// Per-bit sync chain plus stability counter; registered change and go-press pulses.
module switch_conditioner #(
  parameter int W               = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GO_BIT          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] switchesRaw,
  output logic [W-1:0] switchesOut,
  output logic         changed,
  output logic         goPress
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]                  stable_q, stable_d;
  logic                          changed_q, changed_d;
  logic                          go_q, go_d;
  logic [W-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int b = 0; b < W; b++) begin
      if (s[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        // Counter clears on acceptance, so it can never wrap.
        stable_d[b] = s[b];
        cnt_d[b]    = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
    changed_d = |(stable_d ^ stable_q);
    go_d      = stable_d[GO_BIT] & ~stable_q[GO_BIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], switchesRaw};
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      go_q      <= go_d;
    end
  end

  assign switchesOut = stable_q;
  assign changed     = changed_q;
  assign goPress     = go_q;

endmodule
